// File: rtl/pattern_shift_engine.sv
// -----------------------------------------------------------------------------
// pattern_shift_engine
//
// Holds a WIDTH-bit display pattern and, on each internally generated step,
// shifts, rotates or bounces it. The step rate comes from an on-block
// prescaler clocked by SR_CLK. A step fires every rate+1 enabled cycles.
// A synchronous parallel load overrides stepping.
//
// Ports
//   SR_CLK     in   1           system clock, rising-edge
//   SR_CLR     in   1           asynchronous active-high reset
//   en         in   1           run enable for prescaler and shifting
//   mode       in   3           000 hold, 001 shl, 010 shr, 011 rol,
//                               100 ror, 101 bounce, 11x hold
//   rate       in   PRESCALE_W  prescaler terminal count
//   ld         in   1           synchronous parallel load
//   data_in    in   WIDTH       parallel-load value
//   ser_in     in   1           serial fill bit for shift modes
//   shift_out  out  WIDTH       current pattern (registered)
//   step       out  1           pulse in the cycle after a step was applied
//   dir        out  1           bounce direction, 1 = toward MSB
// -----------------------------------------------------------------------------
module pattern_shift_engine #(
   parameter int                WIDTH         = 8,
   parameter int                PRESCALE_W    = 24,
   parameter logic [WIDTH-1:0]  RESET_PATTERN = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic                  SR_CLK,
   input  logic                  SR_CLR,
   input  logic                  en,
   input  logic [2:0]            mode,
   input  logic [PRESCALE_W-1:0] rate,
   input  logic                  ld,
   input  logic [WIDTH-1:0]      data_in,
   input  logic                  ser_in,
   output logic [WIDTH-1:0]      shift_out,
   output logic                  step,
   output logic                  dir
);

   typedef enum logic [2:0] {
      MODE_HOLD   = 3'b000,
      MODE_SHL    = 3'b001,
      MODE_SHR    = 3'b010,
      MODE_ROL    = 3'b011,
      MODE_ROR    = 3'b100,
      MODE_BOUNCE = 3'b101
   } mode_t;

   // Bounce direction doubles as the state of the bounce FSM.
   typedef enum logic {
      DIR_RIGHT = 1'b0,
      DIR_LEFT  = 1'b1
   } dir_t;

   logic [WIDTH-1:0]      r_q;
   logic [PRESCALE_W-1:0] r_cnt;
   logic                  r_step;
   dir_t                  r_dir;

   logic [WIDTH-1:0]      w_q_nxt;
   logic [PRESCALE_W-1:0] w_cnt_nxt;
   logic                  w_step_nxt;
   dir_t                  w_dir_nxt;
   logic                  w_tick;

   // ">=" rather than "==" so that lowering rate below the running count
   // ticks on the next enabled cycle instead of waiting for a wrap.
   assign w_tick = en && (r_cnt >= rate);

   // NOTE: every output of this block gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      w_q_nxt    = r_q;
      w_cnt_nxt  = r_cnt;
      w_step_nxt = 1'b0;
      w_dir_nxt  = r_dir;

      if (ld) begin
         // Load beats a coincident tick: restart counting, no step pulse.
         w_q_nxt   = data_in;
         w_cnt_nxt = '0;
         w_dir_nxt = DIR_LEFT;
      end else if (w_tick) begin
         w_cnt_nxt  = '0;
         w_step_nxt = 1'b1;
         case (mode)
            MODE_SHL: w_q_nxt = {r_q[WIDTH-2:0], ser_in};
            MODE_SHR: w_q_nxt = {ser_in, r_q[WIDTH-1:1]};
            MODE_ROL: w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            MODE_ROR: w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
            MODE_BOUNCE: begin
               // Reaching an end reverses and moves away in the same tick.
               // A zero pattern never hits an end, so dir stays put.
               if (r_dir == DIR_LEFT) begin
                  if (r_q[WIDTH-1]) begin
                     w_dir_nxt = DIR_RIGHT;
                     w_q_nxt   = {1'b0, r_q[WIDTH-1:1]};
                  end else begin
                     w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  if (r_q[0]) begin
                     w_dir_nxt = DIR_LEFT;
                     w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
                  end else begin
                     w_q_nxt   = {1'b0, r_q[WIDTH-1:1]};
                  end
               end
            end
            // Hold and the reserved codes leave the pattern, but still step.
            default: w_q_nxt = r_q;
         endcase
      end else if (en) begin
         w_cnt_nxt = r_cnt + PRESCALE_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge SR_CLK or posedge SR_CLR) begin
      if (SR_CLR) begin
         r_q    <= RESET_PATTERN;
         r_cnt  <= '0;
         r_step <= 1'b0;
         r_dir  <= DIR_LEFT;
      end else begin
         r_q    <= w_q_nxt;
         r_cnt  <= w_cnt_nxt;
         r_step <= w_step_nxt;
         r_dir  <= w_dir_nxt;
      end
   end

   assign shift_out = r_q;
   assign step      = r_step;
   assign dir       = r_dir;

endmodule
